wb_test_ctrl: RTL and testbench

Memory-mapped simulation-control peripheral sitting on the core's data-side Wishbone bus beside the dual-port memory: the test program writes its result (riscv-tests `tohost` convention) and console characters here instead of the bench inferring them from trap lines and register-file peeks. It latches pass/fail and exit code, enforces a tick timeout, buffers console bytes in a FIFO drained by the bench, and exposes a 64-bit cycle counter to software.

---
 rtl/wb_test_ctrl_if.sv | 24 ++
 rtl/wb_test_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_wb_test_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_test_ctrl_if.sv
// -----------------------------------------------------------------------------
// wb_test_ctrl_if
// Pipelined Wishbone B4 bundle between the core's data-side interconnect and
// the simulation-control peripheral.
//   cyc, stb, we     : bus cycle, strobe, write enable  (master -> slave)
//   adr, dat_w, sel  : byte address, write data, byte selects (master -> slave)
//   dat_r, ack, stall: read data, one-cycle acknowledge, stall (slave -> master)
// -----------------------------------------------------------------------------
interface wb_test_ctrl_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;
    logic        stall;

    modport master (output cyc, stb, we, adr, dat_w, sel,
                    input  dat_r, ack, stall);
    modport slave  (input  cyc, stb, we, adr, dat_w, sel,
                    output dat_r, ack, stall);
endinterface

// File: rtl/wb_test_ctrl.sv
// -----------------------------------------------------------------------------
// wb_test_ctrl
// Simulation-control peripheral on the data-side Wishbone bus. Software writes
// its tohost result and console bytes here; the block latches done/pass/exit
// code, forces a timeout completion after MAX_TICKS cycles, buffers console
// bytes in a FIFO drained by the bench, and exposes a 64-bit cycle counter.
//
// Ports
//   clk, rstn        : clock, asynchronous active-low reset
//   wb (slave)       : Wishbone B4 pipelined slave, never stalls
//   done_o, pass_o   : sticky completion flag, pass (code 0, no timeout)
//   code_o           : 31-bit exit code
//   timeout_o        : completion was forced by the tick limit
//   putc_valid_o     : console FIFO not empty
//   putc_data_o      : console FIFO head byte (0 while empty)
//   putc_ready_i     : bench consumes the head byte when valid & ready
//
// Register map (word index adr[4:2]):
//   0 TOHOST (W), 1 CONSOLE (W), 2 CYCLE_LO (R), 3 CYCLE_HI (R), 4 STATUS (R)
//
// CYCLE_INIT is the counter's reset value; it stays 0 in real use and exists
// so the low-word wrap can be reached without billions of cycles.
// -----------------------------------------------------------------------------
module wb_test_ctrl #(
    parameter int unsigned MAX_TICKS      = 100000,
    parameter int unsigned FIFO_DEPTH_POT = 4,
    parameter int unsigned TIMEOUT_CODE   = 666,
    parameter logic [63:0] CYCLE_INIT     = 64'd0
) (
    input  logic                 clk,
    input  logic                 rstn,
    wb_test_ctrl_if.slave        wb,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [30:0]          code_o,
    output logic                 timeout_o,
    output logic                 putc_valid_o,
    output logic [7:0]           putc_data_o,
    input  logic                 putc_ready_i
);

    localparam int unsigned DEPTH      = 1 << FIFO_DEPTH_POT;
    localparam int unsigned CW         = FIFO_DEPTH_POT + 1;
    localparam logic [31:0] TICK_LIMIT = 32'(MAX_TICKS - 1);

    logic                      ack_q, ack_d;
    logic [31:0]               dat_q, dat_d;
    logic                      done_q, done_d;
    logic                      pass_q, pass_d;
    logic                      timeout_q, timeout_d;
    logic [30:0]               code_q, code_d;
    logic                      ovf_q, ovf_d;
    logic [63:0]               cyc_q, cyc_d;
    logic [31:0]               snap_q, snap_d;
    logic [31:0]               tick_q, tick_d;
    logic [FIFO_DEPTH_POT-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_POT-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [7:0]                mem [DEPTH];

    logic        accept, rd, wr_tohost, wr_console;
    logic        fifo_full, push, pop;
    logic [2:0]  idx;
    logic [31:0] status;
    logic        unused_bits;

    assign accept     = wb.cyc & wb.stb;
    assign idx        = wb.adr[4:2];
    assign rd         = accept & ~wb.we;
    assign wr_tohost  = accept & wb.we & (idx == 3'd0) & (wb.sel == 4'b1111);
    assign wr_console = accept & wb.we & (idx == 3'd1) & wb.sel[0];

    assign unused_bits = ^{wb.adr[31:5], wb.adr[1:0]};

    assign putc_valid_o = (cnt_q != '0);
    assign fifo_full    = (cnt_q == CW'(DEPTH));
    assign pop          = putc_valid_o & putc_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push         = wr_console & (~fifo_full | pop);

    always_comb begin
        status           = '0;
        status[0]        = done_q;
        status[1]        = timeout_q;
        status[2]        = pass_q;
        status[3]        = ovf_q;
        status[4 +: CW]  = cnt_q;
    end

    always_comb begin
        ack_d     = accept;
        dat_d     = '0;
        snap_d    = snap_q;
        cyc_d     = cyc_q + 64'd1;
        tick_d    = tick_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        code_d    = code_q;
        ovf_d     = ovf_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;

        if (rd) begin
            case (idx)
                3'd2:    dat_d = cyc_q[31:0];
                3'd3:    dat_d = snap_q;
                3'd4:    dat_d = status;
                default: dat_d = '0;
            endcase
        end

        // Reading the low word freezes the high word for a coherent 64-bit read.
        if (rd && idx == 3'd2) begin
            snap_d = cyc_q[63:32];
        end

        if (!done_q && tick_q != TICK_LIMIT) begin
            tick_d = tick_q + 32'd1;
        end

        // A software completion beats a timeout landing in the same cycle.
        if (!done_q) begin
            if (wr_tohost && wb.dat_w[0]) begin
                done_d = 1'b1;
                code_d = wb.dat_w[31:1];
                pass_d = (wb.dat_w[31:1] == 31'd0);
            end else if (tick_q == TICK_LIMIT) begin
                done_d    = 1'b1;
                timeout_d = 1'b1;
                code_d    = 31'(TIMEOUT_CODE);
                pass_d    = 1'b0;
            end
        end

        if (wr_console && !push) begin
            ovf_d = 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            code_q    <= '0;
            ovf_q     <= 1'b0;
            cyc_q     <= CYCLE_INIT;
            snap_q    <= '0;
            tick_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            code_q    <= code_d;
            ovf_q     <= ovf_d;
            cyc_q     <= cyc_d;
            snap_q    <= snap_d;
            tick_q    <= tick_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Byte storage carries no reset; the head output is gated by valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wb.dat_w[7:0];
        end
    end

    assign putc_data_o = putc_valid_o ? mem[rd_ptr_q] : 8'h00;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign code_o      = code_q;
    assign timeout_o   = timeout_q;
    assign wb.ack      = ack_q;
    assign wb.dat_r    = dat_q;
    assign wb.stall    = 1'b0;

endmodule

// File: tb/tb_wb_test_ctrl.sv
module tb_wb_test_ctrl;

    logic clk;
    logic rstn;

    wb_test_ctrl_if bi ();
    wb_test_ctrl_if bc ();

    logic        done_a, pass_a, timeout_a, pv_a, rdy_a;
    logic [30:0] code_a;
    logic [7:0]  pd_a;
    logic        done_c, pass_c, timeout_c, pv_c;
    logic [30:0] code_c;
    logic [7:0]  pd_c;

    int n_assert = 0;
    int n_fail   = 0;

    wb_test_ctrl #(
        .MAX_TICKS(50), .FIFO_DEPTH_POT(4), .TIMEOUT_CODE(666)
    ) dut (
        .clk(clk), .rstn(rstn), .wb(bi),
        .done_o(done_a), .pass_o(pass_a), .code_o(code_a),
        .timeout_o(timeout_a), .putc_valid_o(pv_a), .putc_data_o(pd_a),
        .putc_ready_i(rdy_a)
    );

    wb_test_ctrl #(
        .MAX_TICKS(100000), .FIFO_DEPTH_POT(4), .TIMEOUT_CODE(666),
        .CYCLE_INIT(64'h0000_0000_FFFF_FFFF)
    ) dut_c (
        .clk(clk), .rstn(rstn), .wb(bc),
        .done_o(done_c), .pass_o(pass_c), .code_o(code_c),
        .timeout_o(timeout_c), .putc_valid_o(pv_c), .putc_data_o(pd_c),
        .putc_ready_i(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns 1 time unit after the
    // accepting edge, which is the ack cycle.
    task automatic bus(input bit c, input bit we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
        if (c) begin
            bc.cyc = 1'b1; bc.stb = 1'b1; bc.we = we;
            bc.adr = adr; bc.dat_w = dat; bc.sel = sel;
        end else begin
            bi.cyc = 1'b1; bi.stb = 1'b1; bi.we = we;
            bi.adr = adr; bi.dat_w = dat; bi.sel = sel;
        end
        @(posedge clk); #1;
        bi.cyc = 1'b0; bi.stb = 1'b0; bi.we = 1'b0;
        bc.cyc = 1'b0; bc.stb = 1'b0; bc.we = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        rdy_a = 1'b0;
        bi.cyc = 0; bi.stb = 0; bi.we = 0; bi.adr = 0; bi.dat_w = 0; bi.sel = 0;
        bc.cyc = 0; bc.stb = 0; bc.we = 0; bc.adr = 0; bc.dat_w = 0; bc.sel = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", bi.ack, 0);
        chk("rst_dat", bi.dat_r, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_code", code_a, 0);
        chk("rst_timeout", timeout_a, 0);
        chk("rst_pvalid", pv_a, 0);
        chk("rst_pdata", pd_a, 0);
        chk("rst_stall", bi.stall, 0);
        rstn = 1'b1;

        // Counter at first acceptance is 0, status empty, counter advances per cycle
        bus(0, 0, 32'h8, 0, 4'hF);
        chk("cyclo_first_ack", bi.ack, 1);
        chk("cyclo_first", bi.dat_r, 0);
        bus(0, 0, 32'h10, 0, 4'hF);
        chk("status_idle", bi.dat_r, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ack_low", bi.ack, 0);
        bus(0, 0, 32'h8, 0, 4'hF);
        chk("cyclo_later", bi.dat_r, 5);

        // TOHOST pass
        bus(0, 1, 32'h0, 32'h1, 4'hF);
        chk("pass_ack", bi.ack, 1);
        chk("pass_done", done_a, 1);
        chk("pass_pass", pass_a, 1);
        chk("pass_code", code_a, 0);
        bus(0, 0, 32'h10, 0, 4'hF);
        chk("pass_status", bi.dat_r, 32'h5);
        @(posedge clk); #1;
        chk("ack_one_cycle", bi.ack, 0);

        // Asynchronous reset while an ack is pending
        bus(0, 1, 32'h0, 32'h1, 4'hF);
        chk("pend_ack", bi.ack, 1);
        rstn = 1'b0;
        #1;
        chk("arst_ack", bi.ack, 0);
        chk("arst_done", done_a, 0);
        chk("arst_pass", pass_a, 0);

        // TOHOST fail, first completion wins
        do_reset();
        bus(0, 1, 32'h0, 32'hB, 4'hF);
        chk("fail_done", done_a, 1);
        chk("fail_code", code_a, 5);
        chk("fail_pass", pass_a, 0);
        bus(0, 1, 32'h0, 32'h1, 4'hF);
        chk("second_code", code_a, 5);
        chk("second_pass", pass_a, 0);
        bus(0, 0, 32'h10, 0, 4'hF);
        chk("fail_status", bi.dat_r, 32'h1);

        // TOHOST with bit0 clear or partial sel is ignored
        do_reset();
        bus(0, 1, 32'h0, 32'h6, 4'hF);
        chk("bit0_clear_done", done_a, 0);
        bus(0, 1, 32'h0, 32'h1, 4'h1);
        chk("partial_sel_done", done_a, 0);

        // Timeout at cycle 50
        do_reset();
        repeat (49) @(posedge clk);
        #1;
        chk("pre_timeout_done", done_a, 0);
        @(posedge clk); #1;
        chk("to_done", done_a, 1);
        chk("to_timeout", timeout_a, 1);
        chk("to_code", code_a, 666);
        chk("to_pass", pass_a, 0);
        bus(0, 0, 32'h10, 0, 4'hF);
        chk("to_status", bi.dat_r, 32'h3);

        // TOHOST write lands on the limit cycle
        do_reset();
        repeat (49) @(posedge clk);
        #1;
        bus(0, 1, 32'h0, 32'h15, 4'hF);
        chk("race_done", done_a, 1);
        chk("race_timeout", timeout_a, 0);
        chk("race_code", code_a, 10);
        repeat (3) @(posedge clk);
        #1;
        chk("race_timeout_later", timeout_a, 0);

        // Console overflow: 18 bytes into depth 16
        do_reset();
        rdy_a = 1'b0;
        for (int i = 0; i < 18; i++) bus(0, 1, 32'h4, 32'h41 + i, 4'b0001);
        bus(0, 0, 32'h10, 0, 4'hF);
        chk("ovf_status", bi.dat_r, 32'h108);
        rdy_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_valid_%0d", i), pv_a, 1);
            chk($sformatf("drain_data_%0d", i), pd_a, 8'h41 + i);
            @(posedge clk); #1;
        end
        chk("drained_valid", pv_a, 0);
        chk("drained_data", pd_a, 0);

        // Full FIFO with simultaneous push and pop
        do_reset();
        rdy_a = 1'b0;
        for (int i = 0; i < 16; i++) bus(0, 1, 32'h4, 32'h61 + i, 4'b0001);
        rdy_a = 1'b1;
        bus(0, 1, 32'h4, 32'h71, 4'b0001);
        rdy_a = 1'b0;
        chk("fullpp_head", pd_a, 8'h62);
        bus(0, 0, 32'h10, 0, 4'hF);
        chk("fullpp_status", bi.dat_r, 32'h100);
        rdy_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fullpp_data_%0d", i), pd_a, 8'h62 + i);
            @(posedge clk); #1;
        end
        chk("fullpp_empty", pv_a, 0);

        // Empty FIFO push: valid with the ack, then popped
        bus(0, 1, 32'h4, 32'h5A, 4'b0001);
        chk("empty_push_ack", bi.ack, 1);
        chk("empty_push_valid", pv_a, 1);
        chk("empty_push_data", pd_a, 8'h5A);
        @(posedge clk); #1;
        chk("empty_push_popped", pv_a, 0);
        rdy_a = 1'b0;

        // Unmapped index 6
        bus(0, 1, 32'h18, 32'hFFFF_FFFF, 4'hF);
        chk("unmapped_wr_done", done_a, 0);
        bus(0, 0, 32'h18, 0, 4'hF);
        chk("unmapped_ack", bi.ack, 1);
        chk("unmapped_dat", bi.dat_r, 0);

        // Coherent 64-bit read across low-word wrap
        do_reset();
        bus(1, 0, 32'h8, 0, 4'hF);
        chk("wrap_lo", bc.dat_r, 32'hFFFF_FFFF);
        bus(1, 0, 32'hC, 0, 4'hF);
        chk("wrap_hi_snapshot", bc.dat_r, 0);
        bus(1, 0, 32'h8, 0, 4'hF);
        chk("wrap_lo2", bc.dat_r, 1);
        bus(1, 0, 32'hC, 0, 4'hF);
        chk("wrap_hi2", bc.dat_r, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
